ecc_secded_pipe_decoder: RTL and testbench

//  Parametrised SECDED Hamming decoder for DATA_WIDTH-bit words. Two-stage pipeline with valid/ready flow control.

---
 rtl/ecc_secded_pkg.sv | 46 ++++
 rtl/ecc_secded_syndrome.sv | 31 +++
 rtl/ecc_secded_pipe_decoder.sv | 176 +++++++++++++++++
 tb/tb_ecc_secded_pipe_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_secded_pkg.sv
// Shared SECDED definitions: code-layout helpers and error classification,
// used by both the encoder and the pipelined decoder.
package ecc_secded_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN  = 2'd0,
    ECC_SINGLE = 2'd1,
    ECC_DOUBLE = 2'd2
  } ecc_class_e;

  // Smallest P with 2**P >= data_width + P + 1.
  function automatic int parity_width(input int data_width);
    int p;
    p = 1;
    while ((1 << p) < data_width + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) holding data bit idx.
  function automatic int data_to_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < idx) begin
      pos++;
      if (!is_pow2(pos)) cnt++;
    end
    return pos;
  endfunction

  // Data bit index stored at a non-power-of-two Hamming position.
  function automatic int pos_to_data(input int pos);
    int cnt;
    cnt = 0;
    for (int p = 1; p < pos; p++) begin
      if (!is_pow2(p)) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ecc_secded_syndrome.sv
// Combinational syndrome and overall-parity generator for a Hamming codeword
// whose bit i is position i+1.
module ecc_secded_syndrome
  import ecc_secded_pkg::*;
#(
  parameter int CW_WIDTH     = 12,
  parameter int PARITY_WIDTH = 4
) (
  input  logic [CW_WIDTH-1:0]     codeword_i,
  input  logic                    extra_parity_i,
  output logic [PARITY_WIDTH-1:0] syndrome_o,
  output logic                    pe_o
);

  function automatic logic [CW_WIDTH-1:0] cover_mask(input int k);
    logic [CW_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < CW_WIDTH; i++) begin
      m[i] = (((i + 1) >> k) & 1) != 0;
    end
    return m;
  endfunction

  for (genvar gi = 0; gi < PARITY_WIDTH; gi++) begin : g_syn
    localparam logic [CW_WIDTH-1:0] MASK = cover_mask(gi);
    assign syndrome_o[gi] = ^(codeword_i & MASK);
  end

  assign pe_o = (^codeword_i) ^ extra_parity_i;

endmodule

// File: rtl/ecc_secded_pipe_decoder.sv
// Two-stage SECDED decoder with valid/ready flow control, saturating error
// counters and first-error syndrome capture.
module ecc_secded_pipe_decoder
  import ecc_secded_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int COUNT_WIDTH  = 16,
  localparam int PARITY_WIDTH = parity_width(DATA_WIDTH),
  localparam int CW_WIDTH     = DATA_WIDTH + PARITY_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CW_WIDTH-1:0]     in_codeword,
  input  logic                    in_extra_parity,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_err_single,
  output logic                    out_err_double,
  output logic [PARITY_WIDTH-1:0] out_syndrome,
  input  logic                    clear_counters,
  output logic [COUNT_WIDTH-1:0]  sbe_count,
  output logic [COUNT_WIDTH-1:0]  dbe_count,
  output logic                    first_err_valid,
  output logic [PARITY_WIDTH-1:0] first_err_syndrome
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic                    s1_valid_q, s1_valid_d;
  logic [CW_WIDTH-1:0]     s1_cw_q, s1_cw_d;
  logic [PARITY_WIDTH-1:0] s1_syn_q, s1_syn_d;
  logic                    s1_pe_q, s1_pe_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
  logic                    s2_single_q, s2_single_d;
  logic                    s2_double_q, s2_double_d;
  logic [PARITY_WIDTH-1:0] s2_syn_q, s2_syn_d;
  logic [COUNT_WIDTH-1:0]  sbe_q, sbe_d, dbe_q, dbe_d;
  logic                    first_v_q, first_v_d;
  logic [PARITY_WIDTH-1:0] first_syn_q, first_syn_d;

  logic [PARITY_WIDTH-1:0] in_syn;
  logic                    in_pe;
  logic                    s1_ready;
  logic                    out_hs;
  logic [CW_WIDTH-1:0]     cw_fix;
  logic [DATA_WIDTH-1:0]   data_fix;
  ecc_class_e              cls;

  ecc_secded_syndrome #(
    .CW_WIDTH    (CW_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_syndrome (
    .codeword_i    (in_codeword),
    .extra_parity_i(in_extra_parity),
    .syndrome_o    (in_syn),
    .pe_o          (in_pe)
  );

  assign s1_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_ready;
  assign out_hs   = s2_valid_q && out_ready;

  // Only a syndrome pointing inside the codeword with odd overall parity is correctable.
  always_comb begin
    cw_fix = s1_cw_q;
    cls    = ECC_CLEAN;
    if (s1_syn_q == '0) begin
      if (s1_pe_q) cls = ECC_SINGLE;
    end else if (s1_pe_q && (int'(s1_syn_q) <= CW_WIDTH)) begin
      cls = ECC_SINGLE;
      for (int i = 0; i < CW_WIDTH; i++) begin
        if (s1_syn_q == PARITY_WIDTH'(i + 1)) cw_fix[i] = ~cw_fix[i];
      end
    end else begin
      cls = ECC_DOUBLE;
    end
  end

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_extract
    localparam int POS = data_to_pos(gi);
    assign data_fix[gi] = cw_fix[POS-1];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cw_d     = s1_cw_q;
    s1_syn_d    = s1_syn_q;
    s1_pe_d     = s1_pe_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_single_d = s2_single_q;
    s2_double_d = s2_double_q;
    s2_syn_d    = s2_syn_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_valid && in_ready) begin
      s1_cw_d  = in_codeword;
      s1_syn_d = in_syn;
      s1_pe_d  = in_pe;
    end
    if (s1_ready) s2_valid_d = s1_valid_q;
    if (s1_valid_q && s1_ready) begin
      s2_data_d   = data_fix;
      s2_single_d = (cls == ECC_SINGLE);
      s2_double_d = (cls == ECC_DOUBLE);
      s2_syn_d    = s1_syn_q;
    end
  end

  // A clear in the same cycle as a handshake discards that handshake's statistics.
  always_comb begin
    sbe_d       = sbe_q;
    dbe_d       = dbe_q;
    first_v_d   = first_v_q;
    first_syn_d = first_syn_q;
    if (clear_counters) begin
      sbe_d       = '0;
      dbe_d       = '0;
      first_v_d   = 1'b0;
      first_syn_d = '0;
    end else if (out_hs) begin
      if (s2_single_q && (sbe_q != CNT_MAX)) sbe_d = sbe_q + 1'b1;
      if (s2_double_q && (dbe_q != CNT_MAX)) dbe_d = dbe_q + 1'b1;
      if ((s2_single_q || s2_double_q) && !first_v_q) begin
        first_v_d   = 1'b1;
        first_syn_d = s2_syn_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_pe_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
      s2_syn_q    <= '0;
      sbe_q       <= '0;
      dbe_q       <= '0;
      first_v_q   <= 1'b0;
      first_syn_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      s1_pe_q     <= s1_pe_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_single_q <= s2_single_d;
      s2_double_q <= s2_double_d;
      s2_syn_q    <= s2_syn_d;
      sbe_q       <= sbe_d;
      dbe_q       <= dbe_d;
      first_v_q   <= first_v_d;
      first_syn_q <= first_syn_d;
    end
  end

  assign out_valid          = s2_valid_q;
  assign out_data           = s2_data_q;
  assign out_err_single     = s2_single_q;
  assign out_err_double     = s2_double_q;
  assign out_syndrome       = s2_syn_q;
  assign sbe_count          = sbe_q;
  assign dbe_count          = dbe_q;
  assign first_err_valid    = first_v_q;
  assign first_err_syndrome = first_syn_q;

endmodule

// File: tb/tb_ecc_secded_pipe_decoder.sv
// Directed-vector and randomized-stream bench for the pipelined SECDED decoder.
module tb_ecc_secded_pipe_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_ready2;
  logic [11:0] in_codeword;
  logic        in_extra_parity;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        out_err_single, out_err_double;
  logic [3:0]  out_syndrome;
  logic        clear_counters;
  logic [15:0] sbe_count, dbe_count;
  logic        first_err_valid;
  logic [3:0]  first_err_syndrome;
  logic        out_valid2, single2, double2, first_v2;
  logic [7:0]  data2;
  logic [3:0]  syn2, first_syn2;
  logic [1:0]  sbe2, dbe2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecc_secded_pipe_decoder #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_codeword(in_codeword), .in_extra_parity(in_extra_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_single(out_err_single), .out_err_double(out_err_double),
    .out_syndrome(out_syndrome), .clear_counters(clear_counters),
    .sbe_count(sbe_count), .dbe_count(dbe_count),
    .first_err_valid(first_err_valid), .first_err_syndrome(first_err_syndrome)
  );

  ecc_secded_pipe_decoder #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_codeword(in_codeword), .in_extra_parity(in_extra_parity),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(data2),
    .out_err_single(single2), .out_err_double(double2),
    .out_syndrome(syn2), .clear_counters(clear_counters),
    .sbe_count(sbe2), .dbe_count(dbe2),
    .first_err_valid(first_v2), .first_err_syndrome(first_syn2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: returns {extra_parity, codeword}.
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [11:0] cw;
    logic        b;
    int          di;
    cw = '0;
    di = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      b = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if (((p >> k) & 1) == 1 && p != (1 << k)) b = b ^ cw[p-1];
      end
      cw[(1<<k)-1] = b;
    end
    return {^cw, cw};
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [11:0] flip;
    logic        flip_x;
    logic [7:0]  exp_data;
    logic        exp_single;
    logic        exp_double;
    logic [3:0]  exp_syn;
  } vec_t;

  localparam int NV = 11;
  vec_t vec[NV];

  task automatic drive_word(input logic [7:0] d, input logic [11:0] flip, input logic fx);
    logic [12:0] enc;
    enc = encode(d);
    in_codeword     = enc[11:0] ^ flip;
    in_extra_parity = enc[12] ^ fx;
    in_valid        = 1'b1;
  endtask

  initial begin
    logic [12:0] enc;
    logic [15:0] exp_sbe, exp_dbe;
    logic        exp_fv;
    logic [3:0]  exp_fs;
    logic [12:0] exp_q[$];
    logic [12:0] cur, front, held;
    logic        pending, accepted, held_v;
    int          gen, recv, cyc, e, pos;

    vec[0]  = '{"clean_a5",        8'hA5, 12'h000, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd0};
    vec[1]  = '{"sbe_pos5",        8'h3C, 12'h010, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd5};
    vec[2]  = '{"dbe_pos3_pos10",  8'h3C, 12'h204, 1'b0, 8'h1D, 1'b0, 1'b1, 4'd9};
    vec[3]  = '{"extra_only",      8'h3C, 12'h000, 1'b1, 8'h3C, 1'b1, 1'b0, 4'd0};
    vec[4]  = '{"syn14_invalid",   8'h3C, 12'h08A, 1'b0, 8'h3C, 1'b0, 1'b1, 4'd14};
    vec[5]  = '{"sbe_pos12_edge",  8'hA5, 12'h800, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd12};
    vec[6]  = '{"sbe_pos1_parity", 8'h5A, 12'h001, 1'b0, 8'h5A, 1'b1, 1'b0, 4'd1};
    vec[7]  = '{"syn13_invalid",   8'h00, 12'h089, 1'b0, 8'h00, 1'b0, 1'b1, 4'd13};
    vec[8]  = '{"dbe_syn15_even",  8'hFF, 12'h08B, 1'b0, 8'hFF, 1'b0, 1'b1, 4'd15};
    vec[9]  = '{"dbe_bit_extra",   8'h3C, 12'h010, 1'b1, 8'h3E, 1'b0, 1'b1, 4'd5};
    vec[10] = '{"sbe_pos7_data",   8'hFF, 12'h040, 1'b0, 8'hFF, 1'b1, 1'b0, 4'd7};

    rst_n = 1'b0; in_valid = 1'b0; in_codeword = '0; in_extra_parity = 1'b0;
    out_ready = 1'b0; clear_counters = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_counts", 64'({sbe_count, dbe_count}), 64'd0);
    check("rst_first", 64'({first_err_valid, first_err_syndrome}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: one word at a time, latency and statistics checked per word.
    exp_sbe = '0; exp_dbe = '0; exp_fv = 1'b0; exp_fs = '0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_word(vec[i].data, vec[i].flip, vec[i].flip_x);
      out_ready = 1'b1;
      #1 check({vec[i].name, "_in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({vec[i].name, "_lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({vec[i].name, "_lat2"}, 64'(out_valid), 64'd1);
      check({vec[i].name, "_data"}, 64'(out_data), 64'(vec[i].exp_data));
      check({vec[i].name, "_flags"}, 64'({out_err_single, out_err_double}),
            64'({vec[i].exp_single, vec[i].exp_double}));
      check({vec[i].name, "_syn"}, 64'(out_syndrome), 64'(vec[i].exp_syn));
      if (vec[i].exp_single) exp_sbe++;
      if (vec[i].exp_double) exp_dbe++;
      if ((vec[i].exp_single || vec[i].exp_double) && !exp_fv) begin
        exp_fv = 1'b1;
        exp_fs = vec[i].exp_syn;
      end
      @(negedge clk);
      check({vec[i].name, "_sbe"}, 64'(sbe_count), 64'(exp_sbe));
      check({vec[i].name, "_dbe"}, 64'(dbe_count), 64'(exp_dbe));
      check({vec[i].name, "_first"}, 64'({first_err_valid, first_err_syndrome}), 64'({exp_fv, exp_fs}));
      $display("vec %s: data=%h single=%b double=%b syn=%0d sbe=%0d dbe=%0d",
               vec[i].name, out_data, out_err_single, out_err_double, out_syndrome, sbe_count, dbe_count);
    end

    // Saturation: five back-to-back single errors into a 2-bit counter.
    clear_counters = 1'b1;
    @(negedge clk);
    clear_counters = 1'b0;
    for (int j = 0; j < 5; j++) begin
      drive_word(8'(j * 37), 12'(1 << j), 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_sbe_2bit", 64'(sbe2), 64'd3);
    check("sat_sbe_16bit", 64'(sbe_count), 64'd5);
    check("sat_first_syn", 64'({first_v2, first_syn2}), 64'({1'b1, 4'd1}));
    $display("saturation: sbe2=%0d sbe=%0d", sbe2, sbe_count);

    // Clear coinciding with an error handshake.
    clear_counters = 1'b1;
    @(negedge clk);
    clear_counters = 1'b0;
    drive_word(8'h3C, 12'h010, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clear_counters = 1'b1;
    #1 check("clr_pre_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    clear_counters = 1'b0;
    check("clr_sbe", 64'(sbe_count), 64'd0);
    check("clr_first_valid", 64'(first_err_valid), 64'd0);
    $display("clear+handshake: sbe=%0d first_valid=%b", sbe_count, first_err_valid);

    // Reset with two words in flight.
    out_ready = 1'b0;
    drive_word(8'h11, 12'h000, 1'b0);
    @(negedge clk);
    drive_word(8'h22, 12'h000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    $display("reset in flight: out_valid=%b", out_valid);

    // Random stream with random backpressure, checked against an expected-word queue.
    gen = 0; recv = 0; cyc = 0; pending = 1'b0; accepted = 1'b0; held_v = 1'b0;
    cur = '0; held = '0;
    while (recv < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (accepted) pending = 1'b0;
      if (!pending && gen < 100 && $urandom_range(0, 3) != 0) begin
        logic [7:0] d;
        d = 8'($urandom);
        e = int'($urandom_range(0, 2));
        if (e == 1) begin
          pos = int'($urandom_range(1, 12));
          drive_word(d, 12'(1 << (pos - 1)), 1'b0);
          cur = {1'b1, 4'(pos), d};
        end else if (e == 2) begin
          drive_word(d, 12'h000, 1'b1);
          cur = {1'b1, 4'd0, d};
        end else begin
          drive_word(d, 12'h000, 1'b0);
          cur = {1'b0, 4'd0, d};
        end
        pending = 1'b1;
        gen++;
      end
      in_valid  = pending;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_payload", 64'({out_err_single, out_syndrome, out_data}), 64'(held));
      end
      held_v = out_valid && !out_ready;
      held   = {out_err_single, out_syndrome, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_word", 64'(out_data), 64'hDEAD);
        end else begin
          front = exp_q.pop_front();
          check("stream_payload", 64'({out_err_single, out_syndrome, out_data}), 64'(front));
          check("stream_double", 64'(out_err_double), 64'd0);
          $display("stream word %0d: data=%h single=%b syn=%0d", recv, out_data, out_err_single, out_syndrome);
        end
        recv++;
      end
      accepted = in_valid && in_ready;
      if (accepted) exp_q.push_back(cur);
    end
    check("stream_received", 64'(recv), 64'd100);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
